sc_statemachine_nivel: RTL
==========================

Name: sc_statemachine_nivel

Overview:
- Level controller for the game's level register.
- Counts scoring events and, after a fixed number of points, drives the level register's active-low load and clear strobes to advance the level or reset it.
- Optionally generates a gameplay speed tick whose period shortens as the level rises.
- Sits between game logic (start button, point and game-over events) and the level register instance.

Parameters:
- NIVEL_DATAWIDTH, 2, width of the level value and level register bus.
- POINTS_PER_LEVEL, 4, point events needed per level-up (≥2).
- POINTS_DATAWIDTH, 4, point counter width; must hold POINTS_PER_LEVEL-1.
- MAX_LEVEL, 3, highest level; no load issued beyond it.
- BASE_TICK_CYCLES, 16, speed-tick period at level 0, in clocks (power of two, ≥2^NIVEL_DATAWIDTH·2).

Ports:
- SC_STATEMACHINE_NIVEL_CLOCK_50  in  1  system clock.
- SC_STATEMACHINE_NIVEL_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_STATEMACHINE_NIVEL_start_InLow  in  1  start button, already synchronised; acts on its falling edge.
- SC_STATEMACHINE_NIVEL_point_InHigh  in  1  one-cycle point event.
- SC_STATEMACHINE_NIVEL_gameover_InHigh  in  1  game-over level.
- SC_STATEMACHINE_NIVEL_level_InBUS  in  NIVEL_DATAWIDTH  current level register output.
- SC_STATEMACHINE_NIVEL_clear_OutLow  out  1  level register clear strobe.
- SC_STATEMACHINE_NIVEL_load_OutLow  out  1  level register load strobe.
- SC_STATEMACHINE_NIVEL_data_OutBUS  out  NIVEL_DATAWIDTH  value to load.
- SC_STATEMACHINE_NIVEL_levelup_OutHigh  out  1  one-cycle level-up pulse.
- SC_STATEMACHINE_NIVEL_playing_OutHigh  out  1  high in PLAY and LOAD.
- SC_STATEMACHINE_NIVEL_tick_OutHigh  out  1  one-cycle speed tick.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state IDLE; clear_OutLow=1; load_OutLow=1; data_OutBUS=0; levelup_OutHigh=0; playing_OutHigh=0; tick_OutHigh=0; point counter 0; tick counter 0; start sample register 1.
- Registered outputs: all outputs are registered Moore outputs, so each strobe appears the cycle after the state is entered.
- Start detection: falling edge is registered sample==1 and current input==0. It is acted on only in IDLE and GAMEOVER and ignored elsewhere.
- IDLE: start falling edge → CLEAR.
- CLEAR (1 cycle): clear_OutLow=0; point counter ← 0; tick counter ← 0 → PLAY.
- PLAY, game-over: gameover_InHigh=1 → GAMEOVER. It has priority over a simultaneous point, which is dropped.
- PLAY, point below threshold: point with counter < POINTS_PER_LEVEL-1 → counter+1.
- PLAY, point at threshold, level below max: point with counter = POINTS_PER_LEVEL-1 and level_InBUS < MAX_LEVEL → counter ← 0; data_OutBUS ← level_InBUS+1 (captured this cycle) → LOAD.
- PLAY, point at threshold, level at max: point with counter = POINTS_PER_LEVEL-1 and level_InBUS ≥ MAX_LEVEL → counter ← 0; no load; stay in PLAY.
- LOAD (1 cycle): load_OutLow=0; levelup_OutHigh=1; tick counter ← 0 → PLAY.
  - A point arriving in LOAD counts toward the new level (counter = 1).
  - gameover_InHigh in LOAD → GAMEOVER after the load completes; the load is never aborted.
- GAMEOVER: all strobes inactive; level value held; start falling edge → CLEAR.
- Width rules: level+1 is computed in NIVEL_DATAWIDTH bits. It cannot wrap because it is guarded by MAX_LEVEL ≤ 2^NIVEL_DATAWIDTH-1.
- Strobe exclusivity: clear_OutLow and load_OutLow are never low in the same cycle.
- Reset mid-LOAD: both strobes return high immediately and the state returns to IDLE.

Optional Feature:
- Macro: SC_STATEMACHINE_NIVEL_SPEEDTICK_EN.
- Defined: the tick counter runs only in PLAY/LOAD with period P = BASE_TICK_CYCLES >> level_InBUS.
  - tick_OutHigh pulses for one cycle when the counter reaches P-1, and the counter then wraps to 0.
  - The counter is reset on CLEAR and LOAD.
- Undefined: tick_OutHigh is tied to 0 and no tick counter is synthesised.

Decomposition:
- Shared package contents:
  - state encoding localparams: IDLE=3'd0, CLEAR=3'd1, PLAY=3'd2, LOAD=3'd3, GAMEOVER=3'd4;
  - strobe idle values.
- Sub-module: the speed tick generator is a natural sub-module, sc_prescaler_nivel, with inputs period select, enable and restart and output tick. It is instantiated only under the macro.

Test Plan (defaults):
- Reset low mid-run → all outputs at reset values the same cycle; start falling edge → clear_OutLow=0 for exactly 1 cycle, then playing_OutHigh=1.
- 4 point pulses at level 0 → on the 4th, one cycle later load_OutLow=0 with data_OutBUS=1 and levelup_OutHigh=1, each for 1 cycle.
- Level 3 and 8 points → no load strobe ever; counter wraps every 4 points.
- Point and gameover in the same PLAY cycle → GAMEOVER, no load, counter unchanged; start edge → CLEAR strobe, counter 0.
- Point during LOAD → next level-up after only 3 further points.
- With SPEEDTICK_EN: tick every 16 cycles at level 0 and every 8 cycles at level 1. Without it, tick_OutHigh stays 0 across 100 cycles of PLAY.

Source files
------------

// File: rtl/sc_statemachine_nivel_pkg.sv
// Shared types for the level controller: FSM state encoding, strobe idle levels
// and the helper that decides when the game is considered running.
// Latency: n/a (declarations only). Backpressure: n/a.
package sc_statemachine_nivel_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CLEAR    = 3'd1,
      PLAY     = 3'd2,
      LOAD     = 3'd3,
      GAMEOVER = 3'd4
   } state_e;

   // Level register strobes are active-low; these are their inactive levels.
   localparam logic CLEAR_STROBE_IDLE = 1'b1;
   localparam logic LOAD_STROBE_IDLE  = 1'b1;

   // The game counts as running while playing or while a level load is in flight.
   function automatic logic is_running(input state_e s);
      return (s == PLAY) || (s == LOAD);
   endfunction

endpackage

// File: rtl/sc_statemachine_nivel_if.sv
// Bundle between game logic / level register and the level controller.
// Latency: n/a (wiring only). Backpressure: none, all signals are levels or one-cycle pulses.
// slave  = the controller: consumes start/point/gameover/level, drives strobes and status.
// master = the surrounding game logic and level register instance.
interface sc_statemachine_nivel_if #(
   parameter int NIVEL_DATAWIDTH = 2
);
   logic                       SC_STATEMACHINE_NIVEL_start_InLow;
   logic                       SC_STATEMACHINE_NIVEL_point_InHigh;
   logic                       SC_STATEMACHINE_NIVEL_gameover_InHigh;
   logic [NIVEL_DATAWIDTH-1:0] SC_STATEMACHINE_NIVEL_level_InBUS;
   logic                       SC_STATEMACHINE_NIVEL_clear_OutLow;
   logic                       SC_STATEMACHINE_NIVEL_load_OutLow;
   logic [NIVEL_DATAWIDTH-1:0] SC_STATEMACHINE_NIVEL_data_OutBUS;
   logic                       SC_STATEMACHINE_NIVEL_levelup_OutHigh;
   logic                       SC_STATEMACHINE_NIVEL_playing_OutHigh;
   logic                       SC_STATEMACHINE_NIVEL_tick_OutHigh;

   modport slave (
      input  SC_STATEMACHINE_NIVEL_start_InLow,
      input  SC_STATEMACHINE_NIVEL_point_InHigh,
      input  SC_STATEMACHINE_NIVEL_gameover_InHigh,
      input  SC_STATEMACHINE_NIVEL_level_InBUS,
      output SC_STATEMACHINE_NIVEL_clear_OutLow,
      output SC_STATEMACHINE_NIVEL_load_OutLow,
      output SC_STATEMACHINE_NIVEL_data_OutBUS,
      output SC_STATEMACHINE_NIVEL_levelup_OutHigh,
      output SC_STATEMACHINE_NIVEL_playing_OutHigh,
      output SC_STATEMACHINE_NIVEL_tick_OutHigh
   );

   modport master (
      output SC_STATEMACHINE_NIVEL_start_InLow,
      output SC_STATEMACHINE_NIVEL_point_InHigh,
      output SC_STATEMACHINE_NIVEL_gameover_InHigh,
      output SC_STATEMACHINE_NIVEL_level_InBUS,
      input  SC_STATEMACHINE_NIVEL_clear_OutLow,
      input  SC_STATEMACHINE_NIVEL_load_OutLow,
      input  SC_STATEMACHINE_NIVEL_data_OutBUS,
      input  SC_STATEMACHINE_NIVEL_levelup_OutHigh,
      input  SC_STATEMACHINE_NIVEL_playing_OutHigh,
      input  SC_STATEMACHINE_NIVEL_tick_OutHigh
   );
endinterface

// File: rtl/sc_statemachine_nivel_prescaler.sv
// Speed tick generator: one-cycle tick every (BASE_TICK_CYCLES >> period_sel) enabled clocks.
// Latency: tick is registered, asserted the clock after the counter reaches period-1.
// Backpressure: none; restart clears the count and wins over enable.
// Ports: clk, rst_n (async active-low), period_sel (current level), enable, restart, tick.
module sc_prescaler_nivel #(
   parameter int SEL_W            = 2,
   parameter int BASE_TICK_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEL_W-1:0] period_sel,
   input  logic             enable,
   input  logic             restart,
   output logic             tick
);
   localparam int CNT_W = $clog2(BASE_TICK_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] per_last;

   always_comb begin
      per_last = CNT_W'((BASE_TICK_CYCLES >> period_sel) - 1);
      cnt_d    = cnt_q;
      tick_d   = 1'b0;
      if (restart) begin
         cnt_d = '0;
      end else if (enable) begin
         // >= rather than == so a level change mid-count can never strand the counter above the new period.
         if (cnt_q >= per_last) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/sc_statemachine_nivel.sv
// Level controller: counts point events and drives the level register's active-low clear/load strobes.
// Latency: all outputs registered Moore outputs, valid the clock after the FSM enters the state.
// Backpressure: none; a load is never aborted, game-over during LOAD takes effect once it completes.
// Ports: SC_STATEMACHINE_NIVEL_CLOCK_50, SC_STATEMACHINE_NIVEL_RESET_InLow (async active-low),
//        bus (slave modport: start/point/gameover/level in; clear/load/data/levelup/playing/tick out).
// Optional speed tick generator enabled by defining SC_STATEMACHINE_NIVEL_SPEEDTICK_EN.
module sc_statemachine_nivel
   import sc_statemachine_nivel_pkg::*;
#(
   parameter int NIVEL_DATAWIDTH  = 2,
   parameter int POINTS_PER_LEVEL = 4,
   parameter int POINTS_DATAWIDTH = 4,
   parameter int MAX_LEVEL        = 3,
   parameter int BASE_TICK_CYCLES = 16
) (
   input  logic                    SC_STATEMACHINE_NIVEL_CLOCK_50,
   input  logic                    SC_STATEMACHINE_NIVEL_RESET_InLow,
   sc_statemachine_nivel_if.slave  bus
);

   // Reject configurations where the counters or level arithmetic could wrap.
   if ((POINTS_PER_LEVEL < 2) ||
       ((POINTS_PER_LEVEL - 1) >= (1 << POINTS_DATAWIDTH)) ||
       (MAX_LEVEL > ((1 << NIVEL_DATAWIDTH) - 1)) ||
       ((BASE_TICK_CYCLES & (BASE_TICK_CYCLES - 1)) != 0) ||
       (BASE_TICK_CYCLES < ((1 << NIVEL_DATAWIDTH) * 2))) begin : g_param_check
      $error("sc_statemachine_nivel: illegal parameter combination");
   end

   localparam logic [POINTS_DATAWIDTH-1:0] PTS_LAST = POINTS_DATAWIDTH'(POINTS_PER_LEVEL - 1);
   localparam logic [POINTS_DATAWIDTH-1:0] PTS_ONE  = POINTS_DATAWIDTH'(1);
   localparam logic [NIVEL_DATAWIDTH-1:0]  LVL_MAX  = NIVEL_DATAWIDTH'(MAX_LEVEL);
   localparam logic [NIVEL_DATAWIDTH-1:0]  LVL_ONE  = NIVEL_DATAWIDTH'(1);

   state_e                      state_q, state_d;
   logic [POINTS_DATAWIDTH-1:0] pts_q, pts_d;
   logic                        start_q, start_d;
   logic                        clear_q, clear_d;
   logic                        load_q, load_d;
   logic [NIVEL_DATAWIDTH-1:0]  data_q, data_d;
   logic                        levelup_q, levelup_d;
   logic                        playing_q, playing_d;
   logic                        start_fall;

   always_comb begin
      start_fall = start_q & ~bus.SC_STATEMACHINE_NIVEL_start_InLow;
      start_d    = bus.SC_STATEMACHINE_NIVEL_start_InLow;
      state_d    = state_q;
      pts_d      = pts_q;
      data_d     = data_q;

      case (state_q)
         IDLE: begin
            if (start_fall) state_d = CLEAR;
         end
         CLEAR: begin
            pts_d   = '0;
            state_d = PLAY;
         end
         PLAY: begin
            // Game-over wins; a point arriving in the same cycle is dropped.
            if (bus.SC_STATEMACHINE_NIVEL_gameover_InHigh) begin
               state_d = GAMEOVER;
            end else if (bus.SC_STATEMACHINE_NIVEL_point_InHigh) begin
               if (pts_q < PTS_LAST) begin
                  pts_d = pts_q + PTS_ONE;
               end else begin
                  pts_d = '0;
                  // At the top level the counter still wraps but no load is issued.
                  if (bus.SC_STATEMACHINE_NIVEL_level_InBUS < LVL_MAX) begin
                     data_d  = bus.SC_STATEMACHINE_NIVEL_level_InBUS + LVL_ONE;
                     state_d = LOAD;
                  end
               end
            end
         end
         LOAD: begin
            // The counter was zeroed on entry, so a point here is the first one of the new level.
            if (bus.SC_STATEMACHINE_NIVEL_point_InHigh) pts_d = pts_q + PTS_ONE;
            state_d = bus.SC_STATEMACHINE_NIVEL_gameover_InHigh ? GAMEOVER : PLAY;
         end
         GAMEOVER: begin
            if (start_fall) state_d = CLEAR;
         end
         default: state_d = IDLE;
      endcase

      // Outputs decoded from the next state so they line up with the registered state.
      clear_d   = (state_d == CLEAR) ? ~CLEAR_STROBE_IDLE : CLEAR_STROBE_IDLE;
      load_d    = (state_d == LOAD)  ? ~LOAD_STROBE_IDLE  : LOAD_STROBE_IDLE;
      levelup_d = (state_d == LOAD);
      playing_d = is_running(state_d);
   end

   always_ff @(posedge SC_STATEMACHINE_NIVEL_CLOCK_50 or negedge SC_STATEMACHINE_NIVEL_RESET_InLow) begin
      if (!SC_STATEMACHINE_NIVEL_RESET_InLow) begin
         state_q   <= IDLE;
         pts_q     <= '0;
         start_q   <= 1'b1;
         clear_q   <= CLEAR_STROBE_IDLE;
         load_q    <= LOAD_STROBE_IDLE;
         data_q    <= '0;
         levelup_q <= 1'b0;
         playing_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pts_q     <= pts_d;
         start_q   <= start_d;
         clear_q   <= clear_d;
         load_q    <= load_d;
         data_q    <= data_d;
         levelup_q <= levelup_d;
         playing_q <= playing_d;
      end
   end

   assign bus.SC_STATEMACHINE_NIVEL_clear_OutLow    = clear_q;
   assign bus.SC_STATEMACHINE_NIVEL_load_OutLow     = load_q;
   assign bus.SC_STATEMACHINE_NIVEL_data_OutBUS     = data_q;
   assign bus.SC_STATEMACHINE_NIVEL_levelup_OutHigh = levelup_q;
   assign bus.SC_STATEMACHINE_NIVEL_playing_OutHigh = playing_q;

`ifdef SC_STATEMACHINE_NIVEL_SPEEDTICK_EN
   logic tick_w;

   // Counter restarts in CLEAR and LOAD so each level starts a fresh period.
   sc_prescaler_nivel #(
      .SEL_W            (NIVEL_DATAWIDTH),
      .BASE_TICK_CYCLES (BASE_TICK_CYCLES)
   ) u_prescaler (
      .clk        (SC_STATEMACHINE_NIVEL_CLOCK_50),
      .rst_n      (SC_STATEMACHINE_NIVEL_RESET_InLow),
      .period_sel (bus.SC_STATEMACHINE_NIVEL_level_InBUS),
      .enable     (is_running(state_q)),
      .restart    ((state_q == CLEAR) || (state_q == LOAD)),
      .tick       (tick_w)
   );

   assign bus.SC_STATEMACHINE_NIVEL_tick_OutHigh = tick_w;
`else
   assign bus.SC_STATEMACHINE_NIVEL_tick_OutHigh = 1'b0;
`endif

endmodule
